aes_enc_arbiter: RTL and testbench

AES_ENC_ARBITER -- requirements
Module: aes_enc_arbiter

---
 rtl/aes_enc_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_aes_enc_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_arbiter.sv
// Two-requester front end for a single AES encryption core.
// Round-robin arbitration, a one-entry key cache that skips the key-expansion
// handshake on a hit, a per-job watchdog, and a response register held until
// the requester takes it.
module aes_enc_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         rsp0_valid,
    output logic [127:0] rsp0_data,
    output logic         rsp0_err,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    output logic [127:0] rsp1_data,
    output logic         rsp1_err,
    input  logic         rsp1_ready,
    input  logic         key_flush,
    output logic [127:0] aes_Kin,
    output logic [127:0] aes_Din,
    output logic         aes_Krdy,
    output logic         aes_Drdy,
    output logic         aes_EN,
    input  logic [127:0] aes_Dout,
    input  logic         aes_Kvld,
    input  logic         aes_Dvld,
    input  logic         aes_BSY,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WAIT_K = 3'd2,
        START  = 3'd3,
        RUN    = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Last RUN cycle before the job is declared dead: the counter starts at 0
    // in the first RUN cycle, so it reaches TIMEOUT on this cycle's edge.
    localparam logic [5:0] LP_CNT_LAST = 6'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic           r_en;
    logic [127:0]   r_key;
    logic [127:0]   r_data;
    logic           r_id;
    logic [127:0]   r_cached_key;
    logic           r_key_valid;
    logic [127:0]   r_result;
    logic           r_err;
    logic [5:0]     r_cnt;
    logic           r_err_timeout;
    logic           r_last_vld;
    logic           r_last_id;

    logic           w_pick1;
    logic           w_accept;
    logic [127:0]   w_sel_key;
    logic [127:0]   w_sel_data;
    logic           w_hit;
    logic           w_fire;
    logic           w_timeout;
    logic           w_rsp_done;

    // Arbitration: a lone requester wins; on contention the one not served
    // last wins, and before anything has been served requester 0 is favoured.
    always_comb begin
        w_pick1 = 1'b0;
        if (req0_valid && req1_valid)
            w_pick1 = r_last_vld && !r_last_id;
        else
            w_pick1 = req1_valid;
    end

    assign w_accept   = (r_state == IDLE) && r_en && (req0_valid || req1_valid);
    assign w_sel_key  = w_pick1 ? req1_key  : req0_key;
    assign w_sel_data = w_pick1 ? req1_data : req0_data;
    assign w_hit      = r_key_valid && (w_sel_key == r_cached_key);
    assign w_fire     = (r_state == START) && !aes_BSY;
    assign w_timeout  = (r_state == RUN) && !aes_Dvld && (r_cnt == LP_CNT_LAST);
    assign w_rsp_done = (r_state == RESP) && (r_id ? rsp1_ready : rsp0_ready);

    // State register; reset aborts any job in flight.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_hit ? START : LOAD;
            LOAD:    w_next = WAIT_K;
            WAIT_K:  if (aes_Kvld) w_next = START;
            START:   if (!aes_BSY) w_next = RUN;
            RUN:     if (aes_Dvld || w_timeout) w_next = RESP;
            RESP:    if (w_rsp_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from state; the core handshakes are mutually exclusive
    // because LOAD and START are distinct states.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_data  = '0;
        rsp1_data  = '0;
        rsp0_err   = 1'b0;
        rsp1_err   = 1'b0;
        aes_Kin    = '0;
        aes_Din    = '0;
        aes_Krdy   = 1'b0;
        aes_Drdy   = 1'b0;
        if (w_accept) begin
            req0_ready = !w_pick1;
            req1_ready = w_pick1;
        end
        if (r_state == LOAD) begin
            aes_Krdy = 1'b1;
            aes_Kin  = r_key;
        end
        if (w_fire) begin
            aes_Drdy = 1'b1;
            aes_Din  = r_data;
        end
        if (r_state == RESP) begin
            if (r_id) begin
                rsp1_valid = 1'b1;
                rsp1_data  = r_result;
                rsp1_err   = r_err;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_data  = r_result;
                rsp0_err   = r_err;
            end
        end
    end

    assign aes_EN      = r_en;
    assign busy        = (r_state != IDLE);
    assign err_timeout = r_err_timeout;

    // Job, cache, watchdog and arbitration bookkeeping.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_en          <= 1'b0;
            r_key         <= '0;
            r_data        <= '0;
            r_id          <= 1'b0;
            r_cached_key  <= '0;
            r_key_valid   <= 1'b0;
            r_result      <= '0;
            r_err         <= 1'b0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
            r_last_vld    <= 1'b0;
            r_last_id     <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (w_accept) begin
                r_key  <= w_sel_key;
                r_data <= w_sel_data;
                r_id   <= w_pick1;
            end
            if (r_state == WAIT_K && aes_Kvld) begin
                r_cached_key <= r_key;
                r_key_valid  <= 1'b1;
            end
            if (w_fire)
                r_cnt <= '0;
            else if (r_state == RUN)
                r_cnt <= r_cnt + 6'd1;
            if (r_state == RUN && aes_Dvld) begin
                r_result <= aes_Dout;
                r_err    <= 1'b0;
            end else if (w_timeout) begin
                r_result      <= '0;
                r_err         <= 1'b1;
                r_err_timeout <= 1'b1;
                r_key_valid   <= 1'b0;
            end
            // A flush overrides a key install landing in the same cycle.
            if (key_flush)
                r_key_valid <= 1'b0;
            if (w_rsp_done) begin
                r_last_vld <= 1'b1;
                r_last_id  <= r_id;
            end
        end
    end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed bench for aes_enc_arbiter with a behavioural AES core that knows
// the FIPS-197 / SP800-38A test vectors, and a response scoreboard.
module tb_aes_enc_arbiter;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] D1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         CLK = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [127:0] req0_key, req0_data, req1_key, req1_data;
    logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_ready, rsp1_ready;
    logic [127:0] rsp0_data, rsp1_data;
    logic         key_flush;
    logic [127:0] aes_Kin, aes_Din, aes_Dout;
    logic         aes_Krdy, aes_Drdy, aes_EN, aes_Kvld, aes_Dvld, aes_BSY;
    logic         busy, err_timeout;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   krdy_cnt = 0;
    int   drdy_cnt = 0;
    bit   withhold = 1'b0;
    bit   flush_on_kvld = 1'b0;

    always #5 CLK = ~CLK;

    aes_enc_arbiter #(.TIMEOUT(32)) dut (
        .CLK(CLK), .rst(rst),
        .req0_valid(req0_valid), .req0_key(req0_key), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_key(req1_key), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
        .key_flush(key_flush),
        .aes_Kin(aes_Kin), .aes_Din(aes_Din), .aes_Krdy(aes_Krdy), .aes_Drdy(aes_Drdy), .aes_EN(aes_EN),
        .aes_Dout(aes_Dout), .aes_Kvld(aes_Kvld), .aes_Dvld(aes_Dvld), .aes_BSY(aes_BSY),
        .busy(busy), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
        if (k == K0 && d == D0) return C0;
        if (k == K1 && d == D1) return C1;
        return k ^ d;
    endfunction

    // Behavioural core: key ready two cycles after Krdy, ciphertext four
    // cycles after Drdy with BSY high meanwhile.
    logic [127:0] m_key, m_data;
    int           kcnt, dcnt;
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            aes_Kvld <= 1'b0; aes_Dvld <= 1'b0; aes_BSY <= 1'b0; aes_Dout <= '0;
            key_flush <= 1'b0; m_key <= '0; m_data <= '0; kcnt <= 0; dcnt <= 0;
        end else begin
            aes_Kvld  <= 1'b0;
            aes_Dvld  <= 1'b0;
            key_flush <= 1'b0;
            if (aes_Krdy) begin
                m_key <= aes_Kin;
                kcnt  <= 2;
            end else if (kcnt != 0) begin
                kcnt <= kcnt - 1;
                if (kcnt == 1) begin
                    aes_Kvld  <= 1'b1;
                    key_flush <= flush_on_kvld;
                end
            end
            if (aes_Drdy) begin
                m_data  <= aes_Din;
                dcnt    <= 4;
                aes_BSY <= 1'b1;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    aes_BSY <= 1'b0;
                    if (!withhold) begin
                        aes_Dvld <= 1'b1;
                        aes_Dout <= aes_ref(m_key, m_data);
                    end
                end
            end
        end
    end

    task automatic take_rsp(input logic id, input logic [127:0] data, input logic err);
        exp_t e;
        chk("rsp_expected", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_id", 128'(id), 128'(e.id));
            chk("rsp_data", data, e.data);
            chk("rsp_err", 128'(err), 128'(e.err));
        end
    endtask

    // Monitor on the falling edge: handshakes, protocol rules, pulse counts.
    always @(negedge CLK) begin
        if (!rst) begin
            if (rsp0_valid || rsp1_valid)
                chk("rsp_onehot", 128'(rsp0_valid && rsp1_valid), 128'd0);
            if (rsp0_valid && rsp0_ready) take_rsp(1'b0, rsp0_data, rsp0_err);
            if (rsp1_valid && rsp1_ready) take_rsp(1'b1, rsp1_data, rsp1_err);
            if (aes_Krdy || aes_Drdy)
                chk("krdy_drdy_excl", 128'(aes_Krdy && aes_Drdy), 128'd0);
            if (aes_Drdy) chk("drdy_while_bsy", 128'(aes_BSY), 128'd0);
            if (req0_ready || req1_ready) chk("ready_while_busy", 128'(busy), 128'd0);
            if (req0_ready) chk("req0_ready_without_valid", 128'(req0_valid), 128'd1);
            if (req1_ready) chk("req1_ready_without_valid", 128'(req1_valid), 128'd1);
            krdy_cnt += int'(aes_Krdy);
            drdy_cnt += int'(aes_Drdy);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic id, input logic [127:0] k, input logic [127:0] d);
        bit got = 1'b0;
        if (id) begin req1_key = k; req1_data = d; req1_valid = 1'b1; end
        else    begin req0_key = k; req0_data = d; req0_valid = 1'b1; end
        for (int n = 0; n < 150 && !got; n++) begin
            @(negedge CLK);
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
        end
        if (got) tick();
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk($sformatf("req%0d_accept", id), 128'(got), 128'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 128'(sb.size()), 128'd0);
        tick();
        chk({tag, "_idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, d0;
        bit seen;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_key = '0; req0_data = '0; req1_key = '0; req1_data = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) tick();

        // Outputs during reset
        chk("rst_aes_EN", 128'(aes_EN), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err_timeout", 128'(err_timeout), 128'd0);
        chk("rst_handshakes", 128'({aes_Krdy, aes_Drdy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 128'd0);
        rst = 1'b0;
        tick();
        chk("aes_EN_after_rst", 128'(aes_EN), 128'd1);

        // Cold cache on requester 0
        k0 = krdy_cnt; d0 = drdy_cnt;
        sb.push_back('{id: 1'b0, data: C0, err: 1'b0});
        issue(1'b0, K0, D0);
        wait_done("cold");
        chk("cold_krdy_pulses", 128'(krdy_cnt - k0), 128'd1);
        chk("cold_drdy_pulses", 128'(drdy_cnt - d0), 128'd1);

        // Cache hit on requester 1, response held back for a few cycles
        k0 = krdy_cnt; d0 = drdy_cnt;
        rsp1_ready = 1'b0;
        sb.push_back('{id: 1'b1, data: C0, err: 1'b0});
        issue(1'b1, K0, D0);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge CLK);
            if (rsp1_valid === 1'b1) seen = 1'b1;
        end
        chk("hold_rsp_seen", 128'(seen), 128'd1);
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            chk("hold_rsp1_valid", 128'(rsp1_valid), 128'd1);
            chk("hold_rsp1_data", rsp1_data, C0);
        end
        tick();
        rsp1_ready = 1'b1;
        wait_done("hit");
        chk("hit_krdy_pulses", 128'(krdy_cnt - k0), 128'd0);
        chk("hit_drdy_pulses", 128'(drdy_cnt - d0), 128'd1);

        // Contention after requester 1 was served: requester 0 goes first
        k0 = krdy_cnt;
        sb.push_back('{id: 1'b0, data: C0, err: 1'b0});
        sb.push_back('{id: 1'b1, data: C1, err: 1'b0});
        fork
            issue(1'b0, K0, D0);
            issue(1'b1, K1, D1);
        join
        wait_done("rr");
        chk("rr_krdy_pulses", 128'(krdy_cnt - k0), 128'd1);

        // Core never returns data: job aborted with error, cache dropped
        withhold = 1'b1;
        sb.push_back('{id: 1'b0, data: '0, err: 1'b1});
        issue(1'b0, K1, D1);
        wait_done("timeout");
        chk("timeout_flag", 128'(err_timeout), 128'd1);
        withhold = 1'b0;
        k0 = krdy_cnt;
        sb.push_back('{id: 1'b0, data: C1, err: 1'b0});
        issue(1'b0, K1, D1);
        wait_done("after_timeout");
        chk("after_timeout_krdy", 128'(krdy_cnt - k0), 128'd1);
        chk("timeout_flag_sticky", 128'(err_timeout), 128'd1);

        // Reset in RUN: aborted job must produce nothing
        issue(1'b1, K0, D0);
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge CLK);
            if (aes_Drdy === 1'b1) seen = 1'b1;
        end
        chk("abort_drdy_seen", 128'(seen), 128'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_err_timeout", 128'(err_timeout), 128'd0);
        chk("midrst_outputs", 128'({aes_EN, aes_Krdy, aes_Drdy, rsp0_valid, rsp1_valid}), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        k0 = krdy_cnt;
        sb.push_back('{id: 1'b1, data: C0, err: 1'b0});
        issue(1'b1, K0, D0);
        wait_done("post_rst");
        chk("post_rst_krdy", 128'(krdy_cnt - k0), 128'd1);

        // Flush coinciding with key install: job fine, key not retained
        flush_on_kvld = 1'b1;
        k0 = krdy_cnt;
        sb.push_back('{id: 1'b0, data: C1, err: 1'b0});
        issue(1'b0, K1, D1);
        wait_done("flush");
        chk("flush_krdy", 128'(krdy_cnt - k0), 128'd1);
        flush_on_kvld = 1'b0;
        k0 = krdy_cnt;
        sb.push_back('{id: 1'b0, data: C1, err: 1'b0});
        issue(1'b0, K1, D1);
        wait_done("after_flush");
        chk("after_flush_krdy", 128'(krdy_cnt - k0), 128'd1);
        k0 = krdy_cnt;
        sb.push_back('{id: 1'b0, data: C1, err: 1'b0});
        issue(1'b0, K1, D1);
        wait_done("rehit");
        chk("rehit_krdy", 128'(krdy_cnt - k0), 128'd0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
